// File: rtl/tetris_pkg.sv
// Shared board geometry and piece types for the Tetris datapath.
// A piece is three 10-bit rows anchored at shapeRowPos (top row of the piece).
package tetris_pkg;

    localparam int ROWS       = 20;
    localparam int COLS       = 10;
    localparam int SHAPE_ROWS = 3;
    localparam int POS_W      = 5;

    localparam logic [POS_W-1:0] POS_MIN = 5'd2;
    localparam logic [POS_W-1:0] POS_MAX = 5'd19;

    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    typedef struct packed {
        logic [SHAPE_ROWS-1:0][COLS-1:0] shape;
        logic [POS_W-1:0]                row_pos;
    } shape_t;

    // Column 9 is the left edge, so a left move is a shift toward the MSB.
    function automatic shape_t shift_left(input shape_t s);
        shape_t res;
        res = s;
        for (int r = 0; r < SHAPE_ROWS; r++) begin
            res.shape[r] = {s.shape[r][COLS-2:0], 1'b0};
        end
        return res;
    endfunction

    function automatic logic pos_valid(input logic [POS_W-1:0] pos);
        return (pos >= POS_MIN) && (pos <= POS_MAX);
    endfunction

endpackage

// File: rtl/shape_place.sv
// Combinational placement of a 3-row piece onto an otherwise empty board.
// shape[2] lands on row_pos, shape[1] on row_pos-1, shape[0] on row_pos-2.
module shape_place
    import tetris_pkg::*;
(
    input  shape_t shp,
    output board_t mask
);

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            localparam logic [POS_W-1:0] ROW_IDX = POS_W'(gi);
            assign mask[gi] = (shp.row_pos == ROW_IDX)         ? shp.shape[2] :
                              (shp.row_pos == ROW_IDX + 5'd1)  ? shp.shape[1] :
                              (shp.row_pos == ROW_IDX + 5'd2)  ? shp.shape[0] :
                                                                 '0;
        end
    endgenerate

endmodule

// File: rtl/move_left.sv
// Sequential left-move engine: erase the piece, test the shifted footprint,
// then write back either the shifted or the original piece; supports hold-to-repeat.
module move_left
    import tetris_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 16,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   req,
    input  shape_t shp_in,
    input  board_t screen_in,
    output logic   busy,
    output logic   done,
    output logic   moved,
    output logic   err,
    output shape_t shp_out,
    output board_t screen_out
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_CHECK,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    shape_t             shape_q, shape_d;
    board_t             board_q, board_d;
    logic               blocked_q, blocked_d;
    logic               req_prev_q, req_prev_d;
    logic               hold_q, hold_d;
    logic [CNT_W-1:0]   rpt_cnt_q, rpt_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               moved_q, moved_d;
    logic               err_q, err_d;
    shape_t             shp_out_q, shp_out_d;
    board_t             screen_out_q, screen_out_d;

    shape_t shape_shift;
    board_t mask_orig;
    board_t mask_shift;
    logic   edge_hit;
    logic   start;

    assign shape_shift = shift_left(shape_q);
    assign edge_hit    = shape_q.shape[2][COLS-1] | shape_q.shape[1][COLS-1] |
                         shape_q.shape[0][COLS-1];

    shape_place u_place_orig (
        .shp  (shape_q),
        .mask (mask_orig)
    );

    shape_place u_place_shift (
        .shp  (shape_shift),
        .mask (mask_shift)
    );

    always_comb begin
        state_d      = state_q;
        shape_d      = shape_q;
        board_d      = board_q;
        blocked_d    = blocked_q;
        req_prev_d   = req;
        hold_d       = hold_q;
        rpt_cnt_d    = rpt_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        moved_d      = moved_q;
        err_d        = err_q;
        shp_out_d    = shp_out_q;
        screen_out_d = screen_out_q;
        start        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req && (!req_prev_q || (hold_q && rpt_cnt_q == '0))) begin
                    start = 1'b1;
                end else if (req && hold_q) begin
                    rpt_cnt_d = rpt_cnt_q - 1'b1;
                end

                if (start) begin
                    shape_d = shp_in;
                    board_d = screen_in;
                    busy_d  = 1'b1;
                    if (!pos_valid(shp_in.row_pos)) begin
                        // Unplaceable piece: report it and echo the inputs untouched.
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        moved_d      = 1'b0;
                        err_d        = 1'b1;
                        shp_out_d    = shp_in;
                        screen_out_d = screen_in;
                    end else begin
                        state_d = S_ERASE;
                    end
                end
            end

            S_ERASE: begin
                board_d = board_q & ~mask_orig;
                state_d = S_CHECK;
            end

            S_CHECK: begin
                blocked_d = edge_hit | (|(mask_shift & board_q));
                state_d   = S_COMMIT;
            end

            S_COMMIT: begin
                if (!blocked_q) begin
                    board_d = board_q | mask_shift;
                    shape_d = shape_shift;
                end else begin
                    board_d = board_q | mask_orig;
                end
                // Outputs only ever see a fully rebuilt board.
                shp_out_d    = shape_d;
                screen_out_d = board_d;
                moved_d      = !blocked_q;
                err_d        = 1'b0;
                done_d       = 1'b1;
                state_d      = S_DONE;
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (req) begin
                    rpt_cnt_d = hold_q ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);
                    hold_d    = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (!req) begin
            rpt_cnt_d = '0;
            hold_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            shape_q      <= '0;
            board_q      <= '0;
            blocked_q    <= 1'b0;
            req_prev_q   <= 1'b0;
            hold_q       <= 1'b0;
            rpt_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            moved_q      <= 1'b0;
            err_q        <= 1'b0;
            shp_out_q    <= '0;
            screen_out_q <= '0;
        end else begin
            state_q      <= state_d;
            shape_q      <= shape_d;
            board_q      <= board_d;
            blocked_q    <= blocked_d;
            req_prev_q   <= req_prev_d;
            hold_q       <= hold_d;
            rpt_cnt_q    <= rpt_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            moved_q      <= moved_d;
            err_q        <= err_d;
            shp_out_q    <= shp_out_d;
            screen_out_q <= screen_out_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign moved      = moved_q;
    assign err        = err_q;
    assign shp_out    = shp_out_q;
    assign screen_out = screen_out_q;

endmodule

// File: tb/tb_move_left.sv
// Directed bench for move_left: free move, edge, collision, range errors,
// empty piece, auto-repeat timing and asynchronous reset mid-operation.
module tb_move_left;
    import tetris_pkg::*;

    logic   clk = 1'b0;
    logic   reset_n;
    logic   req;
    shape_t shp_in;
    board_t screen_in;
    logic   busy;
    logic   done;
    logic   moved;
    logic   err;
    shape_t shp_out;
    board_t screen_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    move_left #(
        .REPEAT_DELAY  (16),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .shp_in     (shp_in),
        .screen_in  (screen_in),
        .busy       (busy),
        .done       (done),
        .moved      (moved),
        .err        (err),
        .shp_out    (shp_out),
        .screen_out (screen_out)
    );

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise req from a clean low, return cycles from the start cycle to done (-1 on timeout).
    task automatic run_move(input shape_t s, input board_t b, output int lat);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        shp_in    = s;
        screen_in = b;
        req       = 1'b1;
        lat       = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        req = 1'b0;
        $display("move pos=%0d lat=%0d moved=%b err=%b busy=%b", s.row_pos, lat, moved, err, busy);
    endtask

    shape_t s, e_s;
    board_t b, e_b;
    int     lat;
    int     dq[$];
    int     exp_done[4] = '{4, 25, 34, 43};
    int     late_dones;

    initial begin
        reset_n   = 1'b0;
        req       = 1'b0;
        shp_in    = '0;
        screen_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_moved", moved, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_shp", shp_out, '0);
        check("rst_screen", screen_out, '0);
        reset_n = 1'b1;

        // Free move: 2x2 at cols 4-5, rows 9-10
        s = '0; s.shape[2] = 10'h030; s.shape[1] = 10'h030; s.row_pos = 5'd10;
        b = '0; b[10] = 10'h030; b[9] = 10'h030;
        e_b = '0; e_b[10] = 10'h060; e_b[9] = 10'h060;
        e_s = s; e_s.shape[2] = 10'h060; e_s.shape[1] = 10'h060;
        run_move(s, b, lat);
        check("free_lat", lat, 4);
        check("free_busy", busy, 1'b1);
        check("free_moved", moved, 1'b1);
        check("free_err", err, 1'b0);
        check("free_screen", screen_out, e_b);
        check("free_shp", shp_out, e_s);
        @(negedge clk);
        check("free_done_pulse", done, 1'b0);
        check("free_busy_clear", busy, 1'b0);

        // Edge: block already in col 9
        s = '0; s.shape[1] = 10'h200; s.row_pos = 5'd5;
        b = '0; b[4] = 10'h200; b[0] = 10'h3F0; b[19] = 10'h001;
        run_move(s, b, lat);
        check("edge_lat", lat, 4);
        check("edge_moved", moved, 1'b0);
        check("edge_err", err, 1'b0);
        check("edge_screen", screen_out, b);
        check("edge_shp", shp_out, s);

        // Collision: piece col 3 row 8, board col 4 row 8 filled
        s = '0; s.shape[2] = 10'h008; s.row_pos = 5'd8;
        b = '0; b[8] = 10'h018; b[7] = 10'h3FF;
        run_move(s, b, lat);
        check("coll_lat", lat, 4);
        check("coll_moved", moved, 1'b0);
        check("coll_screen", screen_out, b);
        check("coll_row8", screen_out[8], 10'h018);

        // Range: pos 1 and pos 20
        s = '0; s.shape[2] = 10'h001; s.row_pos = 5'd1;
        b = '0; b[1] = 10'h001; b[15] = 10'h155;
        run_move(s, b, lat);
        check("rng1_lat", lat, 1);
        check("rng1_err", err, 1'b1);
        check("rng1_moved", moved, 1'b0);
        check("rng1_screen", screen_out, b);
        check("rng1_shp", shp_out, s);
        s.row_pos = 5'd20;
        b[3] = 10'h2AA;
        run_move(s, b, lat);
        check("rng20_lat", lat, 1);
        check("rng20_err", err, 1'b1);
        check("rng20_moved", moved, 1'b0);
        check("rng20_screen", screen_out, b);
        check("rng20_shp", shp_out, s);

        // Empty piece: moves trivially, board untouched
        s = '0; s.row_pos = 5'd10;
        b = '0; b[10] = 10'h3C3; b[2] = 10'h0F0;
        run_move(s, b, lat);
        check("empty_moved", moved, 1'b1);
        check("empty_err", err, 1'b0);
        check("empty_screen", screen_out, b);

        // Auto-repeat with outputs fed back to inputs
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        s = '0; s.shape[2] = 10'h003; s.shape[1] = 10'h003; s.row_pos = 5'd12;
        b = '0; b[12] = 10'h003; b[11] = 10'h003;
        shp_in = s; screen_in = b; req = 1'b1;
        for (int k = 1; k <= 43; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dq.push_back(k);
                $display("repeat done at t=%0d moved=%b", k, moved);
                check("rep_moved", moved, 1'b1);
                shp_in    = shp_out;
                screen_in = screen_out;
            end
        end
        req = 1'b0;
        check("rep_count", dq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("rep_time", (i < dq.size()) ? dq[i] : -1, exp_done[i]);
        end
        e_b = '0; e_b[12] = 10'h030; e_b[11] = 10'h030;
        check("rep_screen", screen_out, e_b);
        late_dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) late_dones++;
        end
        check("rep_stop", late_dones, 0);

        // Reset asserted while in CHECK
        s = '0; s.shape[2] = 10'h030; s.shape[1] = 10'h030; s.row_pos = 5'd10;
        b = '0; b[10] = 10'h030; b[9] = 10'h030;
        @(negedge clk);
        shp_in = s; screen_in = b; req = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_screen", screen_out, '0);
        check("mid_rst_moved", moved, 1'b0);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        e_b = '0; e_b[10] = 10'h060; e_b[9] = 10'h060;
        run_move(s, b, lat);
        check("post_rst_lat", lat, 4);
        check("post_rst_moved", moved, 1'b1);
        check("post_rst_screen", screen_out, e_b);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
